alu_exec_unit: RTL and testbench

- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU-control decoder, together with two operands and a shift amount.
- Performs the selected operation and returns a registered result with zero and overflow flags.
- Shifts are iterative, one bit per cycle, so the block has variable latency behind valid/ready handshakes on both the operation side and the result side.
- Sits between the ID/EX register and the EX/MEM register of the multi-cycle/pipelined datapath.

---
 rtl/alu_exec_unit_pkg.sv | 32 +++
 rtl/alu_exec_unit_comb_core.sv | 61 ++++++
 rtl/alu_exec_unit.sv | 148 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit_pkg
//  Description : Shared ALU control codes and execution-unit state encoding.
//                The same code constants are used by the ALU-control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_exec_unit_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SRL = 4'b0011;
  localparam logic [3:0] ALU_SRA = 4'b0100;
  localparam logic [3:0] ALU_NOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1001;
  localparam logic [3:0] ALU_SLL = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SRA) || (code == ALU_SRL) || (code == ALU_SLL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_comb_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_comb_core
//  Description : Single-cycle ALU datapath: logic ops, add/sub with signed
//                overflow, and set-less-than. Shift codes pass B through
//                unchanged (the zero-distance shift result).
//  Ports       : i_ctrl     - 4-bit ALU control code
//                i_a, i_b   - operands
//                o_result   - combinational result
//                o_overflow - signed overflow (add/sub only)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_comb_core
  import alu_exec_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   i_ctrl,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_result,
  output logic         o_overflow
);

  logic [W-1:0] w_sum;
  logic [W-1:0] w_diff;
  logic         w_add_ovf;
  logic         w_sub_ovf;
  logic         w_slt;

  assign w_sum  = i_a + i_b;
  assign w_diff = i_a - i_b;
  // Subtraction is A + ~B + 1, so its operand signs agree when A and B differ.
  assign w_add_ovf = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1]  != i_a[W-1]);
  assign w_sub_ovf = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
  assign w_slt     = ($signed(i_a) < $signed(i_b));

  always_comb begin
    o_result   = w_sum;
    o_overflow = 1'b0;
    case (i_ctrl)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_NOR: o_result = ~(i_a | i_b);
      ALU_SUB: begin
        o_result   = w_diff;
        o_overflow = w_sub_ovf;
      end
      ALU_SLT: o_result = {{(W-1){1'b0}}, w_slt};
      ALU_SRA, ALU_SRL, ALU_SLL: o_result = i_b;
      default: begin
        // ALU_ADD and every unassigned code execute as add
        o_result   = w_sum;
        o_overflow = w_add_ovf;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_unit
//  Description : Execution-stage ALU with registered result, zero and overflow
//                flags. Shifts run one bit per cycle, so operation and result
//                sides use valid/ready handshakes.
//  Ports       : inClk, inRstN           - clock, async active-low reset
//                inOpValid / outOpReady  - operation handshake
//                inALUControl, inA, inB, inShamt - operation and operands
//                outResValid / inResReady - result handshake
//                outResult, outZero, outOverflow  - registered result/flags
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int W  = 32,
  parameter int SW = 5
) (
  input  logic          inClk,
  input  logic          inRstN,
  input  logic          inOpValid,
  output logic          outOpReady,
  input  logic [3:0]    inALUControl,
  input  logic [W-1:0]  inA,
  input  logic [W-1:0]  inB,
  input  logic [SW-1:0] inShamt,
  output logic          outResValid,
  input  logic          inResReady,
  output logic [W-1:0]  outResult,
  output logic          outZero,
  output logic          outOverflow
);

  state_t        r_state;
  logic [W-1:0]  r_result;
  logic          r_zero;
  logic          r_ovf;
  logic          r_res_valid;
  logic          r_op_ready;
  logic [W-1:0]  r_acc;
  logic [SW-1:0] r_cnt;
  logic [3:0]    r_kind;

  logic [W-1:0]  w_core_res;
  logic          w_core_ovf;
  logic          w_is_shift;
  logic [W-1:0]  w_imm_res;
  logic          w_imm_ovf;
  logic [W-1:0]  w_acc_next;

  function automatic logic [W-1:0] shift1(input logic [3:0] kind,
                                          input logic [W-1:0] v);
    case (kind)
      ALU_SRA: shift1 = {v[W-1], v[W-1:1]};
      ALU_SRL: shift1 = {1'b0, v[W-1:1]};
      default: shift1 = {v[W-2:0], 1'b0};
    endcase
  endfunction

  alu_comb_core #(.W(W)) u_core (
    .i_ctrl     (inALUControl),
    .i_a        (inA),
    .i_b        (inB),
    .o_result   (w_core_res),
    .o_overflow (w_core_ovf)
  );

  assign w_is_shift = is_shift(inALUControl);
  assign w_acc_next = shift1(r_kind, r_acc);

  // The accept edge performs the first shift step, so a shift by N finishes
  // N edges after accept; N==1 completes directly from IDLE.
  always_comb begin
    w_imm_res = w_core_res;
    w_imm_ovf = w_core_ovf;
    if (w_is_shift && (inShamt == SW'(1))) begin
      w_imm_res = shift1(inALUControl, inB);
      w_imm_ovf = 1'b0;
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_state     <= ST_IDLE;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_res_valid <= 1'b0;
      r_op_ready  <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_kind      <= ALU_ADD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inOpValid) begin
            r_op_ready <= 1'b0;
            if (w_is_shift && (inShamt > SW'(1))) begin
              r_acc   <= shift1(inALUControl, inB);
              r_cnt   <= inShamt - SW'(1);
              r_kind  <= inALUControl;
              r_state <= ST_SHIFT;
            end else begin
              r_result    <= w_imm_res;
              r_zero      <= (w_imm_res == '0);
              r_ovf       <= w_imm_ovf;
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          if (r_cnt == SW'(1)) begin
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_ovf       <= 1'b0;
            r_res_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_DONE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt - SW'(1);
          end
        end
        ST_DONE: begin
          if (inResReady) begin
            r_res_valid <= 1'b0;
            r_op_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_op_ready <= 1'b1;
        end
      endcase
    end
  end

  assign outOpReady  = r_op_ready;
  assign outResValid = r_res_valid;
  assign outResult   = r_result;
  assign outZero     = r_zero;
  assign outOverflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_exec_unit
//  Description : Self-checking bench for alu_exec_unit with a behavioural
//                reference model and randomized operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          inClk = 1'b0;
  logic          inRstN = 1'b0;
  logic          inOpValid = 1'b0;
  logic          outOpReady;
  logic [3:0]    inALUControl = 4'b0;
  logic [W-1:0]  inA = '0;
  logic [W-1:0]  inB = '0;
  logic [SW-1:0] inShamt = '0;
  logic          outResValid;
  logic          inResReady = 1'b0;
  logic [W-1:0]  outResult;
  logic          outZero;
  logic          outOverflow;

  int n_checks = 0;
  int n_pass   = 0;

  alu_exec_unit #(.W(W), .SW(SW)) dut (
    .inClk        (inClk),
    .inRstN       (inRstN),
    .inOpValid    (inOpValid),
    .outOpReady   (outOpReady),
    .inALUControl (inALUControl),
    .inA          (inA),
    .inB          (inB),
    .inShamt      (inShamt),
    .outResValid  (outResValid),
    .inResReady   (inResReady),
    .outResult    (outResult),
    .outZero      (outZero),
    .outOverflow  (outOverflow)
  );

  always #5 inClk = ~inClk;

  // Behavioural model: plain arithmetic on the architectural definition.
  task automatic ref_model(input logic [3:0] c, input logic [31:0] a,
                           input logic [31:0] b, input int n,
                           output logic [31:0] r, output logic ov,
                           output int lat);
    longint sa, sb, s;
    logic signed [31:0] sbv;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sbv = b;
    ov  = 1'b0;
    lat = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b1001: r = a ^ b;
      4'b0101: r = ~(a | b);
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0100: begin r = sbv >>> n; lat = (n > 0) ? n : 1; end
      4'b0011: begin r = b >> n;    lat = (n > 0) ? n : 1; end
      4'b1011: begin r = b << n;    lat = (n > 0) ? n : 1; end
      4'b0110: begin
        s  = sa - sb;
        r  = a - b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      default: begin
        s  = sa + sb;
        r  = a + b;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
    endcase
  endtask

  // Drives one full operation, including the result handshake.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        output logic [31:0] res, output logic z,
                        output logic ov, output int lat,
                        output logic busy_ready, output logic valid_after,
                        output logic timeout);
    int guard;
    busy_ready = 1'b0;
    timeout    = 1'b0;
    guard      = 0;
    @(negedge inClk);
    while (!outOpReady && guard < 100) begin
      @(negedge inClk);
      guard++;
    end
    if (guard >= 100) timeout = 1'b1;
    inALUControl = c;
    inA          = a;
    inB          = b;
    inShamt      = SW'(n);
    inOpValid    = 1'b1;
    @(posedge inClk);
    #1;
    inOpValid    = 1'b0;
    // Operands after accept must be ignored
    inA          = $urandom;
    inB          = $urandom;
    inShamt      = SW'($urandom);
    inALUControl = 4'($urandom);
    lat = 1;
    while (!outResValid && lat < 64) begin
      if (outOpReady) busy_ready = 1'b1;
      @(posedge inClk);
      #1;
      lat++;
    end
    if (!outResValid) timeout = 1'b1;
    if (outOpReady) busy_ready = 1'b1;
    res = outResult;
    z   = outZero;
    ov  = outOverflow;
    @(negedge inClk);
    inResReady = 1'b1;
    @(posedge inClk);
    #1;
    valid_after = outResValid;
    inResReady  = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge inClk);
    n_checks++; if (outResValid !== 1'b0) $display("FAIL reset_valid: got %b want 0", outResValid); else n_pass++;
    n_checks++; if (outResult !== 32'h0) $display("FAIL reset_result: got %h want 0", outResult); else n_pass++;
    n_checks++; if (outZero !== 1'b1) $display("FAIL reset_zero: got %b want 1", outZero); else n_pass++;
    n_checks++; if (outOverflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", outOverflow); else n_pass++;
    inRstN = 1'b1;
    @(posedge inClk);
    #1;
    n_checks++; if (outOpReady !== 1'b1) $display("FAIL reset_ready: got %b want 1", outOpReady); else n_pass++;
  endtask

  task automatic test_reset_mid_shift;
    @(negedge inClk);
    inALUControl = 4'b1011;
    inB          = 32'h1;
    inA          = 32'h0;
    inShamt      = SW'(20);
    inOpValid    = 1'b1;
    @(posedge inClk);
    #1;
    inOpValid = 1'b0;
    repeat (4) @(posedge inClk);
    #1;
    n_checks++; if (outOpReady !== 1'b0) $display("FAIL midshift_busy: ready got %b want 0", outOpReady); else n_pass++;
    n_checks++; if (outResValid !== 1'b0) $display("FAIL midshift_notdone: valid got %b want 0", outResValid); else n_pass++;
    #1;
    inRstN = 1'b0;
    #1;
    n_checks++; if (outResValid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", outResValid); else n_pass++;
    n_checks++; if (outResult !== 32'h0) $display("FAIL midrst_result: got %h want 0", outResult); else n_pass++;
    n_checks++; if (outOpReady !== 1'b1) $display("FAIL midrst_ready: got %b want 1", outOpReady); else n_pass++;
    n_checks++; if (outZero !== 1'b1) $display("FAIL midrst_zero: got %b want 1", outZero); else n_pass++;
    @(negedge inClk);
    inRstN = 1'b1;
  endtask

  task automatic test_directed;
    logic [3:0]  codes [9] = '{4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b1111,
                               4'b0100, 4'b0011, 4'b1011, 4'b1011};
    logic [31:0] as [9] = '{32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h0, 32'd2,
                            32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] bs [9] = '{32'h1, 32'd5, 32'h1, 32'h0, 32'd3,
                            32'h80000000, 32'h80000000, 32'd3, 32'h1};
    int          ns [9] = '{0, 0, 0, 0, 0, 4, 4, 0, 31};
    logic [31:0] er [9] = '{32'h80000000, 32'h0, 32'h1, 32'hFFFFFFFF, 32'd5,
                            32'hF8000000, 32'h08000000, 32'd3, 32'h80000000};
    logic        eo [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          el [9] = '{1, 1, 1, 1, 1, 4, 4, 1, 31};
    logic [31:0] res;
    logic        z, ov, br, va, to;
    int          lat;
    for (int i = 0; i < 9; i++) begin
      run_op(codes[i], as[i], bs[i], ns[i], res, z, ov, lat, br, va, to);
      n_checks++; if (to) $display("FAIL dir%0d_timeout: got timeout want result", i); else n_pass++;
      n_checks++; if (res !== er[i]) $display("FAIL dir%0d_result: got %h want %h", i, res, er[i]); else n_pass++;
      n_checks++; if (z !== (er[i] == 32'h0)) $display("FAIL dir%0d_zero: got %b want %b", i, z, (er[i] == 32'h0)); else n_pass++;
      n_checks++; if (ov !== eo[i]) $display("FAIL dir%0d_ovf: got %b want %b", i, ov, eo[i]); else n_pass++;
      n_checks++; if (lat != el[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, el[i]); else n_pass++;
      n_checks++; if (br) $display("FAIL dir%0d_ready_busy: got ready=1 while busy want 0", i); else n_pass++;
      n_checks++; if (va !== 1'b0) $display("FAIL dir%0d_valid_drop: got %b want 0", i, va); else n_pass++;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] res;
    logic        z, ov, br, va, to;
    int          lat;
    logic        unstable, ready_seen;
    @(negedge inClk);
    inALUControl = 4'b0110;
    inA          = 32'd3;
    inB          = 32'd10;
    inShamt      = '0;
    inOpValid    = 1'b1;
    @(posedge inClk);
    #1;
    inOpValid = 1'b0;
    n_checks++; if (outResValid !== 1'b1) $display("FAIL bp_valid: got %b want 1", outResValid); else n_pass++;
    unstable   = 1'b0;
    ready_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge inClk);
      inOpValid    = (i == 3);
      inALUControl = 4'b0000;
      inA          = $urandom;
      inB          = $urandom;
      @(posedge inClk);
      #1;
      if (outResult !== 32'hFFFFFFF9 || outZero !== 1'b0 || outOverflow !== 1'b0 ||
          outResValid !== 1'b1) unstable = 1'b1;
      if (outOpReady !== 1'b0) ready_seen = 1'b1;
    end
    inOpValid = 1'b0;
    n_checks++; if (unstable) $display("FAIL bp_stable: got changing result/flags want %h held", 32'hFFFFFFF9); else n_pass++;
    n_checks++; if (ready_seen) $display("FAIL bp_ready: got ready=1 under backpressure want 0"); else n_pass++;
    @(negedge inClk);
    inResReady = 1'b1;
    @(posedge inClk);
    #1;
    inResReady = 1'b0;
    n_checks++; if (outResValid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", outResValid); else n_pass++;
    n_checks++; if (outOpReady !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", outOpReady); else n_pass++;
    run_op(4'b0010, 32'd2, 32'd3, 0, res, z, ov, lat, br, va, to);
    n_checks++; if (res !== 32'd5 || to) $display("FAIL bp_next_op: got %h want %h", res, 32'd5); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] res, a, b, er;
    logic        z, ov, br, va, to, eo;
    logic [3:0]  c;
    int          n, lat, el;
    for (int i = 0; i < 200; i++) begin
      c = 4'($urandom);
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) b = a;
      n = (i % 3 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
      ref_model(c, a, b, n, er, eo, el);
      run_op(c, a, b, n, res, z, ov, lat, br, va, to);
      n_checks++; if (res !== er || to) $display("FAIL rnd%0d_result code=%b a=%h b=%h n=%0d: got %h want %h", i, c, a, b, n, res, er); else n_pass++;
      n_checks++; if (z !== (er == 32'h0)) $display("FAIL rnd%0d_zero: got %b want %b", i, z, (er == 32'h0)); else n_pass++;
      n_checks++; if (ov !== eo) $display("FAIL rnd%0d_ovf code=%b a=%h b=%h: got %b want %b", i, c, a, b, ov, eo); else n_pass++;
      n_checks++; if (lat != el || br || va !== 1'b0) $display("FAIL rnd%0d_timing: got lat=%0d busy_ready=%b valid_after=%b want lat=%0d 0 0", i, lat, br, va, el); else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_shift;
    test_directed;
    test_backpressure;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
